// File: rtl/rsp_packer.sv
// rsp_packer: buffers 32-bit read words in a small FIFO and serializes them
// LSB-first into response bytes, honouring start lane and byte count.
// Ports:
//   sysclk, sys_rstn          clock, async active-low reset
//   start, start_byte,        begin a response (flushes FIFO, aborts current)
//   byte_count
//   word_valid, word_data,    read-word input with ready handshake
//   word_ready
//   byte_take, byte_valid,    byte output consumed by the JTAG interface
//   byte_data
//   busy, done, underrun      response status
module rsp_packer #(
    parameter int DEPTH_LOG2 = 3
) (
    input  logic        sysclk,
    input  logic        sys_rstn,
    input  logic        start,
    input  logic [1:0]  start_byte,
    input  logic [7:0]  byte_count,
    input  logic        word_valid,
    input  logic [31:0] word_data,
    output logic        word_ready,
    input  logic        byte_take,
    output logic        byte_valid,
    output logic [7:0]  byte_data,
    output logic        busy,
    output logic        done,
    output logic        underrun
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CW = DEPTH_LOG2 + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    state_t                state_q, state_d;
    logic [31:0]           mem_q [DEPTH];
    logic [31:0]           mem_d [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [1:0]            lane_q, lane_d;
    logic [7:0]            rem_q, rem_d;
    logic [6:0]            need_q, need_d;
    logic                  byte_valid_q, byte_valid_d;
    logic [7:0]            byte_data_q, byte_data_d;
    logic                  done_q, done_d;
    logic                  underrun_q, underrun_d;

    logic [8:0]  span;
    logic        store;
    logic        pop;
    logic        take_ok;
    logic [31:0] head_word;

    always_comb begin
        state_d    = state_q;
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        cnt_d      = cnt_q;
        lane_d     = lane_q;
        rem_d      = rem_q;
        need_d     = need_q;
        underrun_d = underrun_q;
        done_d     = 1'b0;
        store      = 1'b0;
        pop        = 1'b0;
        take_ok    = byte_take && byte_valid_q;
        // Words needed = ceil((start_byte + byte_count) / 4).
        span = {7'd0, start_byte} + {1'b0, byte_count} + 9'd3;

        if (start) begin
            state_d    = (byte_count != 8'd0) ? RUN : IDLE;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            cnt_d      = '0;
            lane_d     = start_byte;
            rem_d      = byte_count;
            need_d     = span[8:2];
            underrun_d = 1'b0;
            done_d     = (byte_count == 8'd0);
        end else begin
            // Words beyond the last needed one (or in IDLE) are
            // handshaken but dropped.
            store = word_valid && word_ready &&
                    (state_q == RUN) && (need_q != 7'd0);
            pop   = take_ok && ((lane_q == 2'd3) || (rem_q == 8'd1));
            if (store) begin
                mem_d[wr_ptr_q] = word_data;
                wr_ptr_d        = wr_ptr_q + 1'b1;
                need_d          = need_q - 7'd1;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + 1'b1;
            end
            cnt_d = cnt_q + CW'(store) - CW'(pop);
            if (take_ok) begin
                lane_d = lane_q + 2'd1;
                rem_d  = rem_q - 8'd1;
                if (rem_q == 8'd1) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            if (byte_take && (state_q == RUN) && !byte_valid_q) begin
                underrun_d = 1'b1;
            end
        end

        // Bypass: a word written this cycle may become the new head.
        head_word = (store && (rd_ptr_d == wr_ptr_q)) ? word_data
                                                      : mem_q[rd_ptr_d];
        byte_valid_d = (state_d == RUN) && (cnt_d != '0);
        byte_data_d  = byte_valid_d ? head_word[{lane_d, 3'b000} +: 8]
                                    : 8'hFF;
    end

    always_ff @(posedge sysclk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            state_q <= IDLE;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            cnt_q        <= '0;
            lane_q       <= '0;
            rem_q        <= '0;
            need_q       <= '0;
            byte_valid_q <= 1'b0;
            byte_data_q  <= 8'hFF;
            done_q       <= 1'b0;
            underrun_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_q        <= mem_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            cnt_q        <= cnt_d;
            lane_q       <= lane_d;
            rem_q        <= rem_d;
            need_q       <= need_d;
            byte_valid_q <= byte_valid_d;
            byte_data_q  <= byte_data_d;
            done_q       <= done_d;
            underrun_q   <= underrun_d;
        end
    end

    assign word_ready = (cnt_q != FULL);
    assign byte_valid = byte_valid_q;
    assign byte_data  = byte_data_q;
    assign busy       = (state_q == RUN);
    assign done       = done_q;
    assign underrun   = underrun_q;

endmodule

// File: tb/tb_rsp_packer.sv
// tb_rsp_packer: directed vector table plus hand-written sequences
// for backpressure and asynchronous reset of rsp_packer.
module tb_rsp_packer;

    logic        sysclk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  start_byte = '0;
    logic [7:0]  byte_count = '0;
    logic        word_valid = 1'b0;
    logic [31:0] word_data = '0;
    logic        byte_take = 1'b0;
    logic        word_ready;
    logic        byte_valid;
    logic [7:0]  byte_data;
    logic        busy;
    logic        done;
    logic        underrun;

    int checks = 0;
    int errors = 0;

    rsp_packer #(.DEPTH_LOG2(3)) dut (
        .sysclk     (sysclk),
        .sys_rstn   (sys_rstn),
        .start      (start),
        .start_byte (start_byte),
        .byte_count (byte_count),
        .word_valid (word_valid),
        .word_data  (word_data),
        .word_ready (word_ready),
        .byte_take  (byte_take),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    always #5 sysclk = ~sysclk;

    typedef struct {
        logic        st;
        logic [1:0]  sb;
        logic [7:0]  bc;
        logic        wv;
        logic [31:0] wd;
        logic        tk;
        logic        rdy;
        logic        bv;
        logic [7:0]  bd;
        logic        bsy;
        logic        dn;
        logic        ur;
    } vec_t;

    vec_t vt[$];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic add(input logic st, input logic [1:0] sb,
                       input logic [7:0] bc, input logic wv,
                       input logic [31:0] wd, input logic tk,
                       input logic rdy, input logic bv,
                       input logic [7:0] bd, input logic bsy,
                       input logic dn, input logic ur);
        vec_t v;
        v.st = st; v.sb = sb; v.bc = bc; v.wv = wv; v.wd = wd;
        v.tk = tk; v.rdy = rdy; v.bv = bv; v.bd = bd; v.bsy = bsy;
        v.dn = dn; v.ur = ur;
        vt.push_back(v);
    endtask

    task automatic run_rows(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            start      = vt[i].st;
            start_byte = vt[i].sb;
            byte_count = vt[i].bc;
            word_valid = vt[i].wv;
            word_data  = vt[i].wd;
            byte_take  = vt[i].tk;
            @(negedge sysclk);
            chk($sformatf("row%0d word_ready", i), 32'(word_ready), 32'(vt[i].rdy));
            chk($sformatf("row%0d byte_valid", i), 32'(byte_valid), 32'(vt[i].bv));
            chk($sformatf("row%0d byte_data", i), 32'(byte_data), 32'(vt[i].bd));
            chk($sformatf("row%0d busy", i), 32'(busy), 32'(vt[i].bsy));
            chk($sformatf("row%0d done", i), 32'(done), 32'(vt[i].dn));
            chk($sformatf("row%0d underrun", i), 32'(underrun), 32'(vt[i].ur));
        end
        start = 1'b0;
        word_valid = 1'b0;
        byte_take = 1'b0;
    endtask

    function automatic logic [31:0] seq_word(input int i);
        logic [7:0] b;
        b = 8'(4 * i);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    task automatic idle_in();
        start = 1'b0;
        word_valid = 1'b0;
        byte_take = 1'b0;
    endtask

    initial begin
        int nb;
        int guard;
        // aligned full word: rows 0..6
        add(1, 0, 4, 0, 0, 0,            1, 0, 8'hFF, 1, 0, 0);
        add(0, 0, 0, 1, 32'h98765432, 0, 1, 1, 8'h32, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 1, 8'h54, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 1, 8'h76, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 1, 8'h98, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 0, 8'hFF, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,            1, 0, 8'hFF, 0, 0, 0);
        // unaligned spanning read: rows 7..13
        add(1, 3, 5, 0, 0, 0,            1, 0, 8'hFF, 1, 0, 0);
        add(0, 0, 0, 1, 32'hAABBCCDD, 0, 1, 1, 8'hAA, 1, 0, 0);
        add(0, 0, 0, 1, 32'h11223344, 1, 1, 1, 8'h44, 1, 0, 0);
        add(0, 0, 0, 1, 32'h55667788, 1, 1, 1, 8'h33, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 1, 8'h22, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 1, 8'h11, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 0, 8'hFF, 0, 1, 0);
        // underrun: rows 14..19
        add(1, 0, 2, 0, 0, 0,            1, 0, 8'hFF, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 0, 8'hFF, 1, 0, 1);
        add(0, 0, 0, 1, 32'h000055AA, 0, 1, 1, 8'hAA, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1,            1, 1, 8'h55, 1, 0, 1);
        add(0, 0, 0, 0, 0, 1,            1, 0, 8'hFF, 0, 1, 1);
        add(0, 0, 0, 0, 0, 0,            1, 0, 8'hFF, 0, 0, 1);
        // abort: rows 20..27
        add(1, 0, 12, 0, 0, 0,           1, 0, 8'hFF, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 0, 8'hFF, 1, 0, 1);
        add(0, 0, 0, 1, 32'h11111111, 0, 1, 1, 8'h11, 1, 0, 1);
        add(0, 0, 0, 1, 32'h22222222, 0, 1, 1, 8'h11, 1, 0, 1);
        add(1, 1, 1, 1, 32'h33333333, 1, 1, 0, 8'hFF, 1, 0, 0);
        add(0, 0, 0, 1, 32'h0000EE00, 0, 1, 1, 8'hEE, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 0, 8'hFF, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,            1, 0, 8'hFF, 0, 0, 0);
        // zero count, idle push/take ignored: rows 28..34
        add(1, 0, 0, 0, 0, 0,            1, 0, 8'hFF, 0, 1, 0);
        add(0, 0, 0, 1, 32'h12345678, 1, 1, 0, 8'hFF, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0,            1, 0, 8'hFF, 1, 0, 0);
        add(0, 0, 0, 0, 0, 0,            1, 0, 8'hFF, 1, 0, 0);
        add(0, 0, 0, 1, 32'h000000C3, 0, 1, 1, 8'hC3, 1, 0, 0);
        add(0, 0, 0, 0, 0, 1,            1, 0, 8'hFF, 0, 1, 0);
        add(0, 0, 0, 0, 0, 0,            1, 0, 8'hFF, 0, 0, 0);

        @(negedge sysclk);
        @(negedge sysclk);
        chk("rst word_ready", 32'(word_ready), 32'd1);
        chk("rst byte_valid", 32'(byte_valid), 32'd0);
        chk("rst byte_data", 32'(byte_data), 32'hFF);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst underrun", 32'(underrun), 32'd0);
        sys_rstn = 1'b1;
        @(negedge sysclk);

        run_rows(0, vt.size() - 1);

        // backpressure: 40 bytes = 10 words through an 8-deep FIFO
        start = 1'b1;
        start_byte = 2'd0;
        byte_count = 8'd40;
        @(negedge sysclk);
        idle_in();
        for (int i = 0; i < 8; i++) begin
            word_valid = 1'b1;
            word_data = seq_word(i);
            @(negedge sysclk);
        end
        idle_in();
        chk("bp full ready", 32'(word_ready), 32'd0);
        word_valid = 1'b1;
        word_data = seq_word(8);
        @(negedge sysclk);
        idle_in();
        chk("bp full hold", 32'(word_ready), 32'd0);
        nb = 0;
        for (int k = 0; k < 7; k++) begin
            chk("bp valid", 32'(byte_valid), 32'd1);
            chk("bp byte", 32'(byte_data), 32'(nb));
            if (k == 4) chk("bp ready after pop", 32'(word_ready), 32'd1);
            byte_take = 1'b1;
            @(negedge sysclk);
            nb++;
        end
        chk("bp byte", 32'(byte_data), 32'(nb));
        word_valid = 1'b1;
        word_data = seq_word(8);
        @(negedge sysclk);
        nb++;
        chk("bp push+pop ready", 32'(word_ready), 32'd1);
        byte_take = 1'b0;
        word_data = seq_word(9);
        @(negedge sysclk);
        idle_in();
        chk("bp refull ready", 32'(word_ready), 32'd0);
        guard = 0;
        while (nb < 40 && guard < 100) begin
            chk("bp valid", 32'(byte_valid), 32'd1);
            chk("bp byte", 32'(byte_data), 32'(nb));
            byte_take = 1'b1;
            @(negedge sysclk);
            nb++;
            guard++;
        end
        idle_in();
        chk("bp done", 32'(done), 32'd1);
        chk("bp busy", 32'(busy), 32'd0);

        // asynchronous reset mid-response
        start = 1'b1;
        byte_count = 8'd4;
        @(negedge sysclk);
        start = 1'b0;
        word_valid = 1'b1;
        word_data = 32'h98765432;
        @(negedge sysclk);
        idle_in();
        chk("pre-rst valid", 32'(byte_valid), 32'd1);
        @(posedge sysclk);
        #2 sys_rstn = 1'b0;
        #1;
        chk("arst word_ready", 32'(word_ready), 32'd1);
        chk("arst byte_valid", 32'(byte_valid), 32'd0);
        chk("arst byte_data", 32'(byte_data), 32'hFF);
        chk("arst busy", 32'(busy), 32'd0);
        chk("arst done", 32'(done), 32'd0);
        chk("arst underrun", 32'(underrun), 32'd0);
        @(negedge sysclk);
        sys_rstn = 1'b1;
        @(negedge sysclk);
        run_rows(0, 6);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
